// File: rtl/crc8_rx_check.sv
// Receive-side CRC8 checker for packet ingress.
// Recomputes CRC8 (poly 0xCF, init 0xFF, MSB-first) over each packet including
// its trailing CRC byte and forwards the payload with the CRC byte removed.
// One payload byte is always held back so that the byte preceding the CRC byte
// can be tagged as end-of-packet. CRC and length status are flagged on that
// last forwarded beat, and a saturating counter tracks errored and dropped packets.
module crc8_rx_check #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_crc_err,
    output logic             out_len_err,
    output logic [CNT_W-1:0] err_cnt
);

    // The length counter stops at MAX_LEN+1; one more increment must still fit
    // so that "len+1 > MAX_LEN" can be evaluated without overflow.
    localparam int                LEN_W   = $clog2(MAX_LEN + 3);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_SAT = LEN_W'(MAX_LEN + 1);
    // Contribution of each bit of t = crc ^ data, with t0 in the lowest byte.
    localparam logic [63:0]       CRC_COLS = {8'h3B, 8'hFA, 8'h7D, 8'hD9,
                                              8'h8B, 8'hA2, 8'h51, 8'hCF};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // One-byte CRC8 update: the XOR of the column constants of the set bits of crc ^ data.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] t;
        logic [7:0] res;
        t   = crc ^ data;
        res = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (t[i]) begin
                res = res ^ CRC_COLS[8*i +: 8];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t             state_r, state_n_s;
    logic [7:0]         crc_r, crc_n_s, crc_seed_s, crc_next_s;
    logic [LEN_W-1:0]   len_r, len_n_s, len_inc_s;
    logic [7:0]         hold_r;
    logic               hold_first_r;
    logic               out_valid_r, out_sop_r, out_eop_r, out_crc_err_r, out_len_err_r;
    logic [7:0]         out_data_r;
    logic [CNT_W-1:0]   err_cnt_r, err_cnt_n_s;
    logic [CNT_W:0]     cnt_sum_s;
    logic [1:0]         err_inc_s;
    logic               in_ready_s, acc_s;
    logic               emit_s, emit_sop_s, emit_eop_s, emit_crc_err_s, emit_len_err_s;
    logic               runt_s, load_s, load_first_s;

    assign in_ready_s  = !out_valid_r || out_ready;
    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_sop     = out_sop_r;
    assign out_eop     = out_eop_r;
    assign out_crc_err = out_crc_err_r;
    assign out_len_err = out_len_err_r;
    assign err_cnt     = err_cnt_r;

    // Next-state decode: what to emit, what to hold, and how CRC/length evolve for an accepted beat.
    always_comb begin
        acc_s          = in_valid && in_ready_s;
        crc_seed_s     = in_sop ? 8'hFF : crc_r;
        crc_next_s     = crc8_update(crc_seed_s, in_data);
        len_inc_s      = (len_r >= LEN_SAT) ? LEN_SAT : (len_r + LEN_W'(1));
        state_n_s      = state_r;
        crc_n_s        = crc_r;
        len_n_s        = len_r;
        emit_s         = 1'b0;
        emit_sop_s     = 1'b0;
        emit_eop_s     = 1'b0;
        emit_crc_err_s = 1'b0;
        emit_len_err_s = 1'b0;
        runt_s         = 1'b0;
        load_s         = 1'b0;
        load_first_s   = 1'b0;
        if (acc_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_sop && in_eop) begin
                        runt_s = 1'b1;
                    end else if (in_sop) begin
                        load_s       = 1'b1;
                        load_first_s = 1'b1;
                        len_n_s      = LEN_W'(1);
                        crc_n_s      = crc_next_s;
                        state_n_s    = ST_HOLD;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    emit_s     = 1'b1;
                    emit_sop_s = hold_first_r;
                    if (in_sop) begin
                        // Previous packet ended without its CRC byte.
                        emit_eop_s     = 1'b1;
                        emit_crc_err_s = 1'b1;
                        if (in_eop) begin
                            runt_s    = 1'b1;
                            len_n_s   = LEN_W'(0);
                            crc_n_s   = 8'hFF;
                            state_n_s = ST_IDLE;
                        end else begin
                            load_s       = 1'b1;
                            load_first_s = 1'b1;
                            len_n_s      = LEN_W'(1);
                            crc_n_s      = crc_next_s;
                        end
                    end else if (in_eop) begin
                        emit_eop_s     = 1'b1;
                        emit_crc_err_s = (crc_next_s != 8'h00);
                        emit_len_err_s = (len_inc_s > LEN_MAX);
                        len_n_s        = LEN_W'(0);
                        crc_n_s        = 8'hFF;
                        state_n_s      = ST_IDLE;
                    end else begin
                        load_s  = 1'b1;
                        len_n_s = len_inc_s;
                        crc_n_s = crc_next_s;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
        err_inc_s   = {1'b0, emit_s && emit_eop_s && (emit_crc_err_s || emit_len_err_s)}
                    + {1'b0, runt_s};
        cnt_sum_s   = {1'b0, err_cnt_r} + {{(CNT_W - 1){1'b0}}, err_inc_s};
        err_cnt_n_s = cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
    end

    // State, hold byte, CRC/length tracking, output register and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            crc_r         <= 8'hFF;
            len_r         <= LEN_W'(0);
            hold_r        <= 8'h00;
            hold_first_r  <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'h00;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            out_crc_err_r <= 1'b0;
            out_len_err_r <= 1'b0;
            err_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_n_s;
            crc_r     <= crc_n_s;
            len_r     <= len_n_s;
            err_cnt_r <= err_cnt_n_s;
            if (load_s) begin
                hold_r       <= in_data;
                hold_first_r <= load_first_s;
            end
            if (emit_s) begin
                out_valid_r   <= 1'b1;
                out_data_r    <= hold_r;
                out_sop_r     <= emit_sop_s;
                out_eop_r     <= emit_eop_s;
                out_crc_err_r <= emit_crc_err_s;
                out_len_err_r <= emit_len_err_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule
